// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-input stream multiplexer.
// Optional feature macro: STREAM_MUX_LAST_EN (adds in_last/out_last and packet lock).
package stream_mux_pkg;

  // Run-time mode encodings driven on the mode input.
  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Bundle of all stream signals around stream_mux_n.
// slave  : the multiplexer itself.
// master : the environment (producers + consumer).
// Optional feature macro: STREAM_MUX_LAST_EN (adds in_last/out_last).
interface stream_mux_n_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import stream_mux_pkg::*;

  localparam int SELW = clog2_min1(N);

  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N-1:0]      in_valid;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_src;
  logic              out_ready;
`ifdef STREAM_MUX_LAST_EN
  logic [N-1:0]      in_last;
  logic              out_last;
`endif

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
`ifdef STREAM_MUX_LAST_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
`ifdef STREAM_MUX_LAST_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Rotate-priority search: first requester strictly after ptr, wrapping at N.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                  req,
  input  logic [clog2_min1(N)-1:0]      ptr,
  input  logic                          enable,
  output logic                          gnt_valid,
  output logic [clog2_min1(N)-1:0]      gnt_idx
);

  localparam int SELW = clog2_min1(N);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  logic [SELW-1:0] idx_s;
  logic            hit_s;

  // Walk ptr+1 .. ptr+N (mod N) and keep the first index whose request is set.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx_s     = ptr;
    hit_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Explicit compare-and-reset so non-power-of-two N wraps correctly.
      if (idx_s == LAST_IDX) begin
        idx_s = '0;
      end else begin
        idx_s = idx_s + 1'b1;
      end
      hit_s     = enable && !gnt_valid && req[idx_s];
      gnt_idx   = hit_s ? idx_s : gnt_idx;
      gnt_valid = gnt_valid || hit_s;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready stream multiplexer with a one-entry registered output.
// mode selects between an externally chosen channel (sel) and round-robin.
// Optional feature macro: STREAM_MUX_LAST_EN -- when defined, in_last/out_last
// are present and a multi-beat packet locks the grant to its channel until
// its last beat transfers.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_n_if.slave  bus
);

  localparam int SELW = clog2_min1(N);
  localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);
  localparam logic [SELW-1:0] PTR_INIT = SELW'(N - 1);

  // Output register and round-robin pointer.
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_src_q,   out_src_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

`ifdef STREAM_MUX_LAST_EN
  // Packet lock state: locked channel and the mode the packet started in.
  logic            lock_q,     lock_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_rr_q,  lock_rr_d;
  logic            out_last_q, out_last_d;
  logic            ptr_rr_s;
`endif

  logic            load_s;
  logic            sel_ok_s;
  logic            rr_enable_s;
  logic            rr_valid_s;
  logic [SELW-1:0] rr_idx_s;
  logic            grant_valid_s;
  logic [SELW-1:0] grant_idx_s;
  logic [N-1:0]    in_ready_s;

  // The output slot can take a new beat when empty or being drained this cycle.
  assign load_s   = !out_valid_q || bus.out_ready;
  assign sel_ok_s = ({1'b0, bus.sel} < N_EXT);

`ifdef STREAM_MUX_LAST_EN
  assign rr_enable_s = load_s && !lock_q && (bus.mode == MODE_RR);
`else
  assign rr_enable_s = load_s && (bus.mode == MODE_RR);
`endif

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .enable    (rr_enable_s),
    .gnt_valid (rr_valid_s),
    .gnt_idx   (rr_idx_s)
  );

  // Grant selection: lock (if any) beats mode; nothing is granted without load.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    if (!load_s) begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
    end
`ifdef STREAM_MUX_LAST_EN
    else if (lock_q) begin
      grant_valid_s = bus.in_valid[lock_idx_q];
      grant_idx_s   = lock_idx_q;
    end
`endif
    else if (bus.mode == MODE_RR) begin
      grant_valid_s = rr_valid_s;
      grant_idx_s   = rr_idx_s;
    end else if (sel_ok_s) begin
      grant_valid_s = bus.in_valid[bus.sel];
      grant_idx_s   = bus.sel;
    end else begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
    end
  end

  // One-hot ready back to the granted producer; grant already implies load.
  always_comb begin
    in_ready_s = '0;
    if (grant_valid_s) begin
      in_ready_s[grant_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Next state of the output slot, pointer and packet lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    lock_rr_d   = lock_rr_q;
    out_last_d  = out_last_q;
    ptr_rr_s    = lock_q ? lock_rr_q : (bus.mode == MODE_RR);
`endif

    if (load_s) begin
      out_valid_d = grant_valid_s;
    end else begin
      out_valid_d = out_valid_q;
    end

    // A grant always means a transfer: grant requires the channel's valid.
    if (grant_valid_s) begin
      out_data_d = bus.in_data[int'(grant_idx_s)*W +: W];
      out_src_d  = grant_idx_s;
`ifdef STREAM_MUX_LAST_EN
      out_last_d = bus.in_last[grant_idx_s];
      lock_d     = !bus.in_last[grant_idx_s];
      lock_idx_d = grant_idx_s;
      lock_rr_d  = ptr_rr_s;
      // Pointer moves only when a round-robin packet completes.
      if (ptr_rr_s && bus.in_last[grant_idx_s]) begin
        ptr_d = grant_idx_s;
      end else begin
        ptr_d = ptr_q;
      end
`else
      if (bus.mode == MODE_RR) begin
        ptr_d = grant_idx_s;
      end else begin
        ptr_d = ptr_q;
      end
`endif
    end else begin
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      ptr_d      = ptr_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= PTR_INIT;
`ifdef STREAM_MUX_LAST_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      lock_rr_q   <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      lock_rr_q   <= lock_rr_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
`ifdef STREAM_MUX_LAST_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed self-checking bench for stream_mux_n (N=4 and N=3 instances).
// Optional feature macro: STREAM_MUX_LAST_EN enables the packet-lock scenario.
module tb_stream_mux_n;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  stream_mux_n_if #(.N(4), .W(8)) bus4 ();
  stream_mux_n_if #(.N(3), .W(8)) bus3 ();

  stream_mux_n #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  stream_mux_n #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.mode = 1'b0; bus4.sel = 2'd0; bus4.in_valid = 4'b0000;
    bus4.in_data = 32'h40302010; bus4.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b000;
    bus3.in_data = 24'h00005A; bus3.out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    bus4.in_last = 4'b1111;
    bus3.in_last = 3'b111;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", bus4.out_valid);
    else n_pass++;
    n_total++;
    if (bus4.out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", bus4.out_data);
    else n_pass++;
    n_total++;
    if (bus4.out_src !== 2'd0) $display("FAIL reset_src got %0d exp 0", bus4.out_src);
    else n_pass++;
    // ptr resets to N-1, so the first round-robin grant is channel 0.
    bus4.mode = 1'b1; bus4.in_valid = 4'b1111;
    #1;
    n_total++;
    if (bus4.in_ready !== 4'b0001) $display("FAIL reset_first_rr got %b exp 0001", bus4.in_ready);
    else n_pass++;
    bus4.mode = 1'b0; bus4.in_valid = 4'b0000;
    #1;
  endtask

  task automatic test_select();
    bus4.mode = 1'b0; bus4.sel = 2'd2; bus4.in_valid = 4'b1111;
    bus4.in_data = 32'h44A52211; bus4.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus4.in_ready !== 4'b0100) $display("FAIL select_ready got %b exp 0100", bus4.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'hA5 || bus4.out_src !== 2'd2)
      $display("FAIL select_out got v=%0b d=%h s=%0d exp v=1 d=a5 s=2",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    else n_pass++;
    bus4.in_valid = 4'b0000;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'hA5 || bus4.out_src !== 2'd2)
      $display("FAIL select_drain got v=%0b d=%h s=%0d exp v=0 d=a5 s=2",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    else n_pass++;
  endtask

  task automatic test_rr_all();
    logic [7:0] exp_d;
    bus4.mode = 1'b1; bus4.in_valid = 4'b1111;
    bus4.in_data = 32'h40302010; bus4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++;
      if (bus4.in_ready !== 4'(1 << (i % 4)))
        $display("FAIL rr_all_ready[%0d] got %b exp %b", i, bus4.in_ready, 4'(1 << (i % 4)));
      else n_pass++;
      tick();
      exp_d = 8'(((i % 4) + 1) * 16);
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== 2'(i % 4) || bus4.out_data !== exp_d)
        $display("FAIL rr_all_out[%0d] got v=%0b s=%0d d=%h exp v=1 s=%0d d=%h",
                 i, bus4.out_valid, bus4.out_src, bus4.out_data, i % 4, exp_d);
      else n_pass++;
    end
    bus4.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_s [7];
    exp_s = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1};
    bus4.mode = 1'b1; bus4.in_valid = 4'b1010; bus4.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) bus4.in_valid = 4'b0010;
      tick();
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== exp_s[i])
        $display("FAIL rr_sparse[%0d] got v=%0b s=%0d exp v=1 s=%0d",
                 i, bus4.out_valid, bus4.out_src, exp_s[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    // Holding ch1 (data 20); ptr is 1, so the next grant after release is ch2.
    bus4.in_valid = 4'b1111; bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus4.in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", i, bus4.in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== 2'd1 || bus4.out_data !== 8'h20)
        $display("FAIL bp_hold[%0d] got v=%0b s=%0d d=%h exp v=1 s=1 d=20",
                 i, bus4.out_valid, bus4.out_src, bus4.out_data);
      else n_pass++;
    end
    bus4.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus4.in_ready !== 4'b0100) $display("FAIL bp_release_ready got %b exp 0100", bus4.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b1 || bus4.out_src !== 2'd2 || bus4.out_data !== 8'h30)
      $display("FAIL bp_release_out got v=%0b s=%0d d=%h exp v=1 s=2 d=30",
               bus4.out_valid, bus4.out_src, bus4.out_data);
    else n_pass++;
    bus4.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_sel_out_of_range();
    bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b111;
    bus3.in_data = 24'h33225A; bus3.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h5A || bus3.out_src !== 2'd0)
      $display("FAIL n3_beat got v=%0b d=%h s=%0d exp v=1 d=5a s=0",
               bus3.out_valid, bus3.out_data, bus3.out_src);
    else n_pass++;
    bus3.sel = 2'd3;
    #1;
    n_total++;
    if (bus3.in_ready !== 3'b000) $display("FAIL n3_sel3_ready got %b exp 000", bus3.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus3.out_valid !== 1'b0 || bus3.out_data !== 8'h5A)
      $display("FAIL n3_sel3_drain got v=%0b d=%h exp v=0 d=5a", bus3.out_valid, bus3.out_data);
    else n_pass++;
    bus3.in_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    bus4.mode = 1'b1; bus4.in_valid = 4'b0001; bus4.out_ready = 1'b0;
    tick();
    n_total++;
    if (bus4.out_valid !== 1'b1) $display("FAIL rstmid_pre got %0b exp 1", bus4.out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.out_src !== 2'd0 || bus4.out_data !== 8'h00)
      $display("FAIL rstmid_async got v=%0b s=%0d d=%h exp v=0 s=0 d=00",
               bus4.out_valid, bus4.out_src, bus4.out_data);
    else n_pass++;
    rst_n = 1'b1;
    bus4.in_valid = 4'b0000; bus4.out_ready = 1'b1;
    tick();
  endtask

`ifdef STREAM_MUX_LAST_EN
  task automatic test_last_lock();
    logic [1:0] exp_s [4];
    logic [3:0] lasts [4];
    logic       exp_l [4];
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd1};
    lasts = '{4'b1110, 4'b1110, 4'b1111, 4'b1111};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
    // ptr is N-1 after the previous reset, so ch0 wins the first grant.
    bus4.mode = 1'b1; bus4.in_valid = 4'b0011; bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.in_last = lasts[i];
      tick();
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== exp_s[i] || bus4.out_last !== exp_l[i])
        $display("FAIL lock_seq[%0d] got v=%0b s=%0d l=%0b exp v=1 s=%0d l=%0b",
                 i, bus4.out_valid, bus4.out_src, bus4.out_last, exp_s[i], exp_l[i]);
      else n_pass++;
    end
    // ptr=1 now: next grant is ch0, which opens a new packet.
    bus4.in_last = 4'b1110;
    tick();
    n_total++;
    if (bus4.out_src !== 2'd0 || bus4.out_last !== 1'b0)
      $display("FAIL lock_open got s=%0d l=%0b exp s=0 l=0", bus4.out_src, bus4.out_last);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus4.out_valid !== 1'b0) $display("FAIL lock_rst_async got %0b exp 0", bus4.out_valid);
    else n_pass++;
    rst_n = 1'b1;
    bus4.in_valid = 4'b0010;
    #1;
    n_total++;
    if (bus4.in_ready !== 4'b0010) $display("FAIL lock_cleared got %b exp 0010", bus4.in_ready);
    else n_pass++;
    bus4.in_valid = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_select();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_sel_out_of_range();
    test_reset_mid();
`ifdef STREAM_MUX_LAST_EN
    test_last_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-input valid/ready stream multiplexer with a one-entry registered output. It is the successor of the team's fixed 4:1 bit multiplexer, with W-bit data channels, N inputs, and two run-time modes: an externally selected path, or round-robin arbitration across requesting inputs. It sits between several producer streams and one consumer, and gives full throughput with one cycle of latency.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, ≥1.
- SELW, default $clog2(N): select/source index width (derived; do not override).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = SELECT (use sel), 1 = ROUND_ROBIN.
- sel  in  SELW  channel index used in SELECT mode.
- in_valid  in  N  per-channel valid.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_ready  out  N  per-channel ready; at most one bit set.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered data.
- out_src  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat.

## Operation
- load = !out_valid || out_ready. Use combinational logic only on the ready path. There is no bubble when the consumer is always ready.
- Grant computation, evaluated only when load=1:
  - SELECT: grant = sel if sel < N and in_valid[sel]. Otherwise there is no grant.
  - ROUND_ROBIN: scan from ptr+1 upward, wrapping modulo N. Grant the first channel with in_valid set.
- in_ready[k] = load && granted && grant==k. in_ready is 0 for every channel when there is no grant or load=0.
- A transfer on channel k (in_valid[k] && in_ready[k]) captures in_data[k] into out_data and k into out_src, and sets out_valid=1.
- If load=1 and there is no grant: out_valid→0. out_data and out_src hold their values.
- ptr updates to the granted index only on a transfer in ROUND_ROBIN mode. ptr is unchanged in SELECT mode.
- sel ≥ N (N not a power of two): no grant, and out_valid drains normally.
- A mode change takes effect on the next grant evaluation. ptr is preserved across mode changes.
- Arithmetic: the wrap uses explicit compare-and-reset, not a power-of-two mask.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=N-1, so the first round-robin grant starts at channel 0. With out_valid=0, in_ready follows grant immediately after reset.
- Latency: an input transfer in cycle t appears with out_valid=1 in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_valid, out_data and out_src are stable, and all in_ready are 0.
- Simultaneous output accept and input transfer in the same cycle: the register is overwritten with no gap.
- Reset asserted mid-operation: out_valid drops asynchronously. The in-flight beat is discarded. ptr is reset.
- Inputs must not depend combinationally on in_ready. There is no combinational path from in_valid/in_data to out_*.

## Configuration
- STREAM_MUX_LAST_EN defined:
  - Adds in_last (in, N) and out_last (out, 1, registered, reset 0).
  - After a transfer with in_last[k]=0, the grant is locked to k in both modes. The lock ignores sel and round-robin until the beat with in_last[k]=1 transfers.
  - ptr advances only at packet end.
  - A mode or sel change during a lock is deferred until the lock releases.
- STREAM_MUX_LAST_EN undefined:
  - No last ports and no lock.
  - Every beat is arbitrated independently.

## Structure
- Package stream_mux_pkg holds:
  - mode constants MODE_SELECT=1'b0 and MODE_RR=1'b1;
  - a function clog2_min1 returning at least 1.
- Sub-module rr_arbiter (params N; inputs req[N], ptr[SELW], enable; outputs gnt_valid, gnt_idx) contains the rotate-priority search.
- The top level owns ptr, the lock state, the output register and the SELECT path.

## Test plan
- SELECT, N=4, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1:
  - in_ready=4'b0100;
  - next cycle out_valid=1, out_data=A5, out_src=2.
- ROUND_ROBIN, all four valid, out_ready=1 for 8 cycles: out_src sequence 0,1,2,3,0,1,2,3 with no bubbles.
- ROUND_ROBIN, in_valid=4'b1010, ptr after reset:
  - grants are 1,3,1,3;
  - then drop ch3 to get 1,1,1.
- Backpressure: with out_valid=1, hold out_ready=0 for 3 cycles:
  - out_data and out_src stable, in_ready=0;
  - releasing gives the next beat one cycle later.
- N=3, SELECT, sel=3: in_ready=0 and out_valid drains to 0 after one accepted beat.
- STREAM_MUX_LAST_EN, RR, ch0 sends a 3-beat packet while ch1 is valid:
  - out_src=0,0,0 then 1;
  - assert reset mid-packet: out_valid=0 immediately and the lock clears.
